// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: bundle of the two core request ports and the main memory port.
//   req_p/we_p/addr_p/wdata_p : core requests (p = 0, 1), held until ack_p
//   ack_p/rdata_p             : one-cycle completion pulse and per-port read data
//   mem_addr/mem_wdata/mem_rden/mem_wren/mem_q : single-ported main memory
//   busy/gnt                  : arbiter status (not idle / current or last winner)
//   modport slave is the arbiter side, master the cores-plus-memory side.
interface mem_arbiter_rr_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              req_0, req_1, we_0, we_1, ack_0, ack_1;
   logic [ADDR_W-1:0] addr_0, addr_1, mem_addr;
   logic [DATA_W-1:0] wdata_0, wdata_1, rdata_0, rdata_1, mem_wdata, mem_q;
   logic              mem_rden, mem_wren, busy, gnt;
   modport slave (
      input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, mem_q,
      output ack_0, ack_1, rdata_0, rdata_1, mem_addr, mem_wdata, mem_rden, mem_wren, busy, gnt
   );
   modport master (
      output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, mem_q,
      input  ack_0, ack_1, rdata_0, rdata_1, mem_addr, mem_wdata, mem_rden, mem_wren, busy, gnt
   );
endinterface

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: two-port round-robin arbiter serialising one-word accesses to main memory.
//   clk, rst : posedge clock, synchronous active-high reset
//   bus      : mem_arbiter_rr_if.slave (core ports 0/1, memory port, busy, gnt)
//   RD_LAT   : cycles from the mem_rden cycle until mem_q is valid (1..7)
module mem_arbiter_rr #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 2
) (
   input logic clk,
   input logic rst,
   mem_arbiter_rr_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t            state, state_n;
   logic              prio, gnt, we_l, win, any_req;
   logic [2:0]        cnt;
   logic [ADDR_W-1:0] addr_l;
   logic [DATA_W-1:0] wdata_l, rdata_0, rdata_1;
   assign any_req = bus.req_0 || bus.req_1;
   // contested requests go to prio, otherwise to whichever port is asking
   assign win = (bus.req_0 && bus.req_1) ? prio : bus.req_1;
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         prio    <= 1'b0;
         gnt     <= 1'b0;
         we_l    <= 1'b0;
         cnt     <= 3'd0;
         addr_l  <= '0;
         wdata_l <= '0;
         rdata_0 <= '0;
         rdata_1 <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && any_req) begin
            gnt     <= win;
            prio    <= ~win;
            we_l    <= win ? bus.we_1 : bus.we_0;
            addr_l  <= win ? bus.addr_1 : bus.addr_0;
            wdata_l <= win ? bus.wdata_1 : bus.wdata_0;
         end
         cnt <= (state == ISSUE) ? 3'(RD_LAT - 1) : (state == WAIT) ? cnt - 3'd1 : cnt;
         // mem_q is valid in the last WAIT cycle; only the granted port's data changes
         if (state == WAIT && cnt == 3'd0) begin
            if (gnt) rdata_1 <= bus.mem_q;
            else     rdata_0 <= bus.mem_q;
         end
      end
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = any_req ? ISSUE : IDLE;
         ISSUE:   state_n = we_l ? DONE : WAIT;
         WAIT:    state_n = (cnt == 3'd0) ? DONE : WAIT;
         default: state_n = IDLE;
      endcase
   end
   // latched address/data double as the memory bus, so they hold while idle
   assign bus.mem_addr  = addr_l;
   assign bus.mem_wdata = wdata_l;
   assign bus.mem_wren  = (state == ISSUE) && we_l;
   assign bus.mem_rden  = (state == ISSUE) && !we_l;
   assign bus.ack_0     = (state == DONE) && !gnt;
   assign bus.ack_1     = (state == DONE) && gnt;
   assign bus.busy      = state != IDLE;
   assign bus.gnt       = gnt;
   assign bus.rdata_0   = rdata_0;
   assign bus.rdata_1   = rdata_1;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed stimulus, a transaction-schedule model checked every cycle, literal checks.
module tb_mem_arbiter_rr;
   localparam int AW = 12, DW = 32, RD_LAT = 2;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   mem_arbiter_rr_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   mem_arbiter_rr #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
   int tests = 0, fails = 0, cyc = 0, rd_cyc = -100, rden_cnt = 0, both_cnt = 0;
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] m_mem [0:(1<<AW)-1];
   logic [DW-1:0] rd_val = '0;
   task automatic chk(string n, logic [63:0] a, logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
      end
   endtask
   // main memory: data appears on mem_q exactly RD_LAT cycles after the rden cycle, garbage otherwise
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rden) begin
         rd_cyc   <= cyc;
         rd_val   <= mem[bus.mem_addr];
         rden_cnt <= rden_cnt + 1;
      end
      if (bus.mem_rden && bus.mem_wren) both_cnt <= both_cnt + 1;
   end
   assign bus.mem_q = (cyc == rd_cyc + RD_LAT) ? rd_val : 32'hBAD0_BAD0;
   // model: a transaction granted in cycle t0 issues in t0+1 and acks in t0+2 (write) or t0+2+RD_LAT (read)
   int t0 = -1, k, len;
   logic m_idle, mp = 1'b0, m_we = 1'b0, m_prio = 1'b0, m_gnt = 1'b0;
   logic e_ack0, e_ack1, e_rden, e_wren;
   logic [AW-1:0] m_addr = '0, e_addr = '0;
   logic [DW-1:0] m_wdata = '0, e_wdata = '0, e_rd0 = '0, e_rd1 = '0;
   initial forever begin
      @(negedge clk);
      m_idle = t0 < 0;
      k      = cyc - t0;
      len    = m_we ? 2 : 2 + RD_LAT;
      if (!m_idle && k == len && !m_we) begin
         if (mp) e_rd1 = m_mem[m_addr];
         else    e_rd0 = m_mem[m_addr];
      end
      e_ack0 = !m_idle && k == len && !mp;
      e_ack1 = !m_idle && k == len && mp;
      e_rden = !m_idle && k == 1 && !m_we;
      e_wren = !m_idle && k == 1 && m_we;
      chk("ctl{ack1,ack0,rden,wren,busy,gnt}",
          {bus.ack_1, bus.ack_0, bus.mem_rden, bus.mem_wren, bus.busy, bus.gnt},
          {e_ack1, e_ack0, e_rden, e_wren, !m_idle, m_gnt});
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_wdata", bus.mem_wdata, e_wdata);
      chk("rdata_0", bus.rdata_0, e_rd0);
      chk("rdata_1", bus.rdata_1, e_rd1);
      if (e_wren) m_mem[m_addr] = m_wdata;
      if (!m_idle && k == len) t0 = -1;
      if (rst) begin
         t0 = -1; m_prio = 1'b0; m_gnt = 1'b0; e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
      end else if (m_idle && (bus.req_0 || bus.req_1)) begin
         mp      = (bus.req_0 && bus.req_1) ? m_prio : bus.req_1;
         t0      = cyc;
         m_we    = mp ? bus.we_1 : bus.we_0;
         m_addr  = mp ? bus.addr_1 : bus.addr_0;
         m_wdata = mp ? bus.wdata_1 : bus.wdata_0;
         m_gnt   = mp;
         m_prio  = ~mp;
         e_addr  = m_addr;
         e_wdata = m_wdata;
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic req(input bit p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p) begin bus.req_1 = 1'b1; bus.we_1 = we; bus.addr_1 = a; bus.wdata_1 = d; end
      else   begin bus.req_0 = 1'b1; bus.we_0 = we; bus.addr_0 = a; bus.wdata_0 = d; end
   endtask
   int base, a0, a1, acks;
   int order [8];
   initial begin
      bus.req_0 = 0; bus.req_1 = 0; bus.we_0 = 0; bus.we_1 = 0;
      bus.addr_0 = '0; bus.addr_1 = '0; bus.wdata_0 = '0; bus.wdata_1 = '0;
      repeat (3) tick();
      chk("reset ctl", {bus.ack_1, bus.ack_0, bus.mem_rden, bus.mem_wren, bus.busy, bus.gnt}, 0);
      chk("reset mem_addr", bus.mem_addr, 0);
      chk("reset rdata_0", bus.rdata_0, 0);
      // single write on port 0
      rst = 0;
      req(0, 1, 12'h0A5, 32'hDEADBEEF);
      tick();
      chk("wr mem_wren", bus.mem_wren, 1);
      chk("wr mem_addr", bus.mem_addr, 12'h0A5);
      chk("wr mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
      tick();
      chk("wr ack_0", bus.ack_0, 1);
      chk("wr ack_1", bus.ack_1, 0);
      chk("wr gnt", bus.gnt, 0);
      bus.req_0 = 0;
      tick();
      // single read on port 1
      req(1, 0, 12'h0A5, 0);
      tick();
      chk("rd mem_rden", bus.mem_rden, 1);
      repeat (3) tick();
      chk("rd ack_1", bus.ack_1, 1);
      chk("rd rdata_1", bus.rdata_1, 32'hDEADBEEF);
      chk("rd rdata_0", bus.rdata_0, 0);
      bus.req_1 = 0;
      tick();
      // simultaneous reads straight after reset
      rst = 1;
      tick();
      rst = 0;
      base = rden_cnt;
      req(0, 0, 12'h0A5, 0);
      req(1, 0, 12'h0A5, 0);
      repeat (4) tick();
      chk("both ack_0 c4", bus.ack_0, 1);
      chk("both rdata_0", bus.rdata_0, 32'hDEADBEEF);
      bus.req_0 = 0;
      tick();
      chk("both busy c5", bus.busy, 0);
      tick();
      chk("both gnt c6", bus.gnt, 1);
      repeat (3) tick();
      chk("both ack_1 c9", bus.ack_1, 1);
      chk("both rdata_1", bus.rdata_1, 32'hDEADBEEF);
      bus.req_1 = 0;
      tick();
      chk("both rden pulses", rden_cnt - base, 2);
      // continuous contested writes: strict alternation
      a0 = 0; a1 = 0; acks = 0;
      req(0, 1, 12'h010, 32'h100);
      req(1, 1, 12'h020, 32'h200);
      for (int n = 0; n < 60 && acks < 8; n++) begin
         tick();
         if (bus.ack_0) begin a0++; order[acks] = 0; acks++; bus.wdata_0 = bus.wdata_0 + 1; end
         if (bus.ack_1) begin a1++; order[acks] = 1; acks++; bus.wdata_1 = bus.wdata_1 + 1; end
      end
      bus.req_0 = 0; bus.req_1 = 0;
      tick();
      chk("rr acks port 0", a0, 4);
      chk("rr acks port 1", a1, 4);
      for (int i = 0; i < 8; i++) chk("rr order", order[i], i % 2);
      chk("rr never both enables", both_cnt, 0);
      // reset during WAIT of a port-0 read
      req(0, 0, 12'h0A5, 0);
      tick();
      chk("rst rden", bus.mem_rden, 1);
      tick();
      chk("rst busy in WAIT", bus.busy, 1);
      rst = 1;
      bus.req_0 = 0;
      tick();
      chk("rst ctl", {bus.ack_1, bus.ack_0, bus.mem_rden, bus.mem_wren, bus.busy, bus.gnt}, 0);
      chk("rst rdata_0", bus.rdata_0, 0);
      chk("rst mem_addr", bus.mem_addr, 0);
      chk("rst mem_wdata", bus.mem_wdata, 0);
      rst = 0;
      req(1, 1, 12'h0FF, 32'hCAFEF00D);
      repeat (2) tick();
      chk("post-rst ack_1", bus.ack_1, 1);
      bus.req_1 = 0;
      tick();
      // write then read back, including the top address
      req(0, 1, 12'h3FF, 32'h12345678);
      repeat (2) tick();
      chk("3ff wr ack_0", bus.ack_0, 1);
      bus.req_0 = 0;
      tick();
      req(1, 0, 12'h3FF, 0);
      repeat (4) tick();
      chk("3ff rd ack_1", bus.ack_1, 1);
      chk("3ff rdata_1", bus.rdata_1, 32'h12345678);
      bus.req_1 = 0;
      tick();
      req(1, 1, 12'hFFF, 32'hA5A55A5A);
      repeat (2) tick();
      bus.req_1 = 0;
      tick();
      req(0, 0, 12'hFFF, 0);
      repeat (4) tick();
      chk("fff rd ack_0", bus.ack_0, 1);
      chk("fff rdata_0", bus.rdata_0, 32'hA5A55A5A);
      chk("fff rdata_1 kept", bus.rdata_1, 32'h12345678);
      bus.req_0 = 0;
      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
